// File: rtl/fetch_unit_pkg.sv
// Shared core definitions: PC/instruction widths, bubble encoding and fetch FSM states.
package fetch_unit_pkg;

    localparam int unsigned PcWidth   = 25;
    localparam int unsigned InstWidth = 32;

    // add r0,r0,r0 encodes as all zeros.
    localparam logic [InstWidth-1:0] Bubble = '0;

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StHold,
        StSquash
    } fetch_state_e;

    // Word-addressed sequential successor; wraps naturally at 2^PcWidth.
    function automatic logic [PcWidth-1:0] pc_next(input logic [PcWidth-1:0] pc);
        return pc + PcWidth'(1);
    endfunction

endpackage

// File: rtl/inst_mem.sv
// Synchronous-read instruction BRAM with one-cycle latency and a load port.
module inst_mem
    import fetch_unit_pkg::*;
#(
    parameter int unsigned AddrWidth = 10
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic [AddrWidth-1:0] addr,
    output logic [InstWidth-1:0] rdata,
    input  logic                 we,
    input  logic [AddrWidth-1:0] waddr,
    input  logic [InstWidth-1:0] wdata
);

    localparam int unsigned Depth = 2 ** AddrWidth;

    logic [InstWidth-1:0] mem [Depth];

    // en low keeps rdata stable so a frozen pipeline sees the same word on resume.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the BRAM address, pairs returning data with its PC,
// holds on decode stalls and squashes one cycle after a redirect.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 n_stall,
    input  logic                 dec_nstall,
    input  logic                 redirect,
    input  logic [PcWidth-1:0]   redirect_pc,
    output logic [PcWidth-1:0]   imem_addr,
    input  logic [InstWidth-1:0] imem_rdata,
    output logic [InstWidth-1:0] inst,
    output logic [PcWidth-1:0]   if_pc
);

    fetch_state_e         state_q, state_d;
    logic [PcWidth-1:0]   fpc_q, fpc_d;
    logic [PcWidth-1:0]   opc_q, opc_d;
    logic [InstWidth-1:0] hold_q, hold_d;

    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        opc_d   = opc_q;
        hold_d  = hold_q;

        if (n_stall) begin
            if (redirect) begin
                fpc_d   = redirect_pc;
                state_d = StSquash;
            end else begin
                unique case (state_q)
                    StBoot, StSquash: begin
                        fpc_d   = pc_next(fpc_q);
                        opc_d   = fpc_q;
                        state_d = StRun;
                    end
                    StRun: begin
                        if (dec_nstall) begin
                            fpc_d = pc_next(fpc_q);
                            opc_d = fpc_q;
                        end else begin
                            hold_d  = imem_rdata;
                            state_d = StHold;
                        end
                    end
                    StHold: begin
                        // The BRAM has been re-reading fpc during the hold, so leaving
                        // HOLD pairs that word with fpc and moves the read one ahead.
                        if (dec_nstall) begin
                            fpc_d   = pc_next(fpc_q);
                            opc_d   = fpc_q;
                            state_d = StRun;
                        end
                    end
                    default: state_d = StBoot;
                endcase
            end
        end
    end

    always_comb begin
        inst  = Bubble;
        if_pc = '0;
        unique case (state_q)
            StRun: begin
                inst  = imem_rdata;
                if_pc = opc_q;
            end
            StHold: begin
                inst  = hold_q;
                if_pc = opc_q;
            end
            default: begin
                inst  = Bubble;
                if_pc = '0;
            end
        endcase
    end

    assign imem_addr = fpc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StBoot;
            fpc_q   <= '0;
            opc_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            opc_q   <= opc_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit + inst_mem; model tracks the presented PC and the next PC to deliver.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int unsigned MemAw    = 10;
    localparam int unsigned MemDepth = 2 ** MemAw;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 n_stall;
    logic                 dec_nstall;
    logic                 redirect;
    logic [PcWidth-1:0]   redirect_pc;
    logic [PcWidth-1:0]   imem_addr;
    logic [InstWidth-1:0] imem_rdata;
    logic [InstWidth-1:0] inst;
    logic [PcWidth-1:0]   if_pc;
    logic                 mem_we;
    logic [MemAw-1:0]     mem_waddr;
    logic [InstWidth-1:0] mem_wdata;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .n_stall    (n_stall),
        .dec_nstall (dec_nstall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .if_pc      (if_pc)
    );

    inst_mem #(.AddrWidth(MemAw)) u_mem (
        .clk  (clk),
        .en   (n_stall),
        .addr (imem_addr[MemAw-1:0]),
        .rdata(imem_rdata),
        .we   (mem_we),
        .waddr(mem_waddr),
        .wdata(mem_wdata)
    );

    // Reference: the decode-visible stream. m_valid=0 means a bubble is shown.
    logic [InstWidth-1:0] mem_model [MemDepth];
    bit                   m_valid;
    logic [PcWidth-1:0]   m_pc;
    logic [PcWidth-1:0]   m_next;
    logic [81:0]          want;
    int                   checks = 0;
    int                   errors = 0;

    function automatic logic [81:0] expected_view();
        logic [InstWidth-1:0] e_inst;
        logic [PcWidth-1:0]   e_pc;
        e_inst = m_valid ? mem_model[m_pc[MemAw-1:0]] : 32'h0;
        e_pc   = m_valid ? m_pc : '0;
        return {e_inst, e_pc, m_next};
    endfunction

    // Advance one clock and apply the stream rules to the inputs seen at that edge.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0;
            m_pc    = '0;
            m_next  = '0;
        end else if (n_stall) begin
            if (redirect) begin
                m_valid = 1'b0;
                m_next  = redirect_pc;
            end else if (!m_valid || dec_nstall) begin
                m_valid = 1'b1;
                m_pc    = m_next;
                m_next  = m_next + 1'b1;
            end
        end
        #1;
        want = expected_view();
    endtask

    task automatic drive(input logic ns, input logic dn, input logic rd, input logic [24:0] tgt);
        n_stall     = ns;
        dec_nstall  = dn;
        redirect    = rd;
        redirect_pc = tgt;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 25'h123);
        step();
        step();
        checks++;
        if ({inst, if_pc, imem_addr} !== 82'h0) begin
            errors++;
            $display("FAIL reset: got inst=%h if_pc=%h addr=%h, want all zero",
                     inst, if_pc, imem_addr);
        end
    endtask

    task automatic test_sequential();
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0, '0);
        step();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i < 4 && (if_pc !== 25'(i) || inst !== 32'(100 + i))) begin
                errors++;
                $display("FAIL seq_const i=%0d: got if_pc=%h inst=%0d, want if_pc=%h inst=%0d",
                         i, if_pc, inst, i, 100 + i);
            end else if ({inst, if_pc, imem_addr} !== want) begin
                errors++;
                $display("FAIL seq i=%0d: got %h %h %h, want %h", i, inst, if_pc, imem_addr, want);
            end
            step();
        end
    endtask

    task automatic test_decode_stall();
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0, '0);
        for (int k = 0; k < 20 && !(m_valid && m_pc == 25'd5); k++) step();
        checks++;
        if (if_pc !== 25'd5) begin
            errors++;
            $display("FAIL stall_reach: got if_pc=%h, want 5", if_pc);
        end
        dec_nstall = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) dec_nstall = 1'b1;
            if (c > 0) begin
                checks++;
                if (if_pc !== 25'd5 || inst !== 32'd105 || {inst, if_pc, imem_addr} !== want) begin
                    errors++;
                    $display("FAIL stall_hold c=%0d: got if_pc=%h inst=%0d addr=%h, want pc 5 inst 105",
                             c, if_pc, inst, imem_addr);
                end
            end
            step();
        end
        checks++;
        if (if_pc !== 25'd6 || inst !== 32'd106) begin
            errors++;
            $display("FAIL stall_release: got if_pc=%h inst=%0d, want 6/106", if_pc, inst);
        end
        step();
        checks++;
        if (if_pc !== 25'd7 || {inst, if_pc, imem_addr} !== want) begin
            errors++;
            $display("FAIL stall_after: got if_pc=%h inst=%0d, want 7 (%h)", if_pc, inst, want);
        end
    endtask

    task automatic test_redirect();
        drive(1'b1, 1'b1, 1'b1, 25'h40);
        step();
        checks++;
        if (inst !== 32'h0 || if_pc !== 25'h0 || {inst, if_pc, imem_addr} !== want) begin
            errors++;
            $display("FAIL redir_bubble: got inst=%h if_pc=%h addr=%h", inst, if_pc, imem_addr);
        end
        redirect = 1'b0;
        step();
        checks++;
        if (if_pc !== 25'h40 || inst !== 32'd164) begin
            errors++;
            $display("FAIL redir_target: got if_pc=%h inst=%0d, want 40/164", if_pc, inst);
        end
    endtask

    task automatic test_redirect_in_hold();
        drive(1'b1, 1'b0, 1'b0, '0);
        step();
        checks++;
        if ({inst, if_pc, imem_addr} !== want) begin
            errors++;
            $display("FAIL hold_enter: got %h %h %h, want %h", inst, if_pc, imem_addr, want);
        end
        drive(1'b1, 1'b0, 1'b1, 25'h123);
        step();
        checks++;
        if (inst !== 32'h0 || if_pc !== 25'h0) begin
            errors++;
            $display("FAIL hold_redir_bubble: got inst=%h if_pc=%h", inst, if_pc);
        end
        drive(1'b1, 1'b0, 1'b0, '0);
        step();
        checks++;
        if (if_pc !== 25'h123 || inst !== mem_model[10'h123]) begin
            errors++;
            $display("FAIL hold_redir_target: got if_pc=%h inst=%h, want 123/%h",
                     if_pc, inst, mem_model[10'h123]);
        end
        dec_nstall = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b1, 1'b1, 25'h200);
        step();
        redirect_pc = 25'h2A0;
        step();
        checks++;
        if (inst !== 32'h0 || if_pc !== 25'h0 || imem_addr !== 25'h2A0) begin
            errors++;
            $display("FAIL b2b_bubble: got inst=%h if_pc=%h addr=%h, want 0/0/2a0",
                     inst, if_pc, imem_addr);
        end
        redirect = 1'b0;
        step();
        checks++;
        if (if_pc !== 25'h2A0 || {inst, if_pc, imem_addr} !== want) begin
            errors++;
            $display("FAIL b2b_target: got if_pc=%h inst=%h, want 2a0 (%h)", if_pc, inst, want);
        end
    endtask

    task automatic test_freeze();
        for (int s = 0; s < 4; s++) begin
            drive(1'b1, 1'b1, 1'b0, '0);
            case (s)
                0: begin rst = 1'b1; step(); rst = 1'b0; end
                1: begin step(); step(); end
                2: begin dec_nstall = 1'b0; step(); end
                default: begin redirect = 1'b1; redirect_pc = 25'h3F0; step(); end
            endcase
            for (int c = 0; c < 5; c++) begin
                drive(1'b0, 1'($urandom), 1'($urandom), 25'($urandom));
                step();
                checks++;
                if ({inst, if_pc, imem_addr} !== want) begin
                    errors++;
                    $display("FAIL freeze s=%0d c=%0d: got %h %h %h, want %h",
                             s, c, inst, if_pc, imem_addr, want);
                end
            end
            drive(1'b1, 1'b1, 1'b0, '0);
            for (int c = 0; c < 3; c++) begin
                step();
                checks++;
                if ({inst, if_pc, imem_addr} !== want) begin
                    errors++;
                    $display("FAIL resume s=%0d c=%0d: got %h %h %h, want %h",
                             s, c, inst, if_pc, imem_addr, want);
                end
            end
        end
    endtask

    task automatic test_wrap();
        drive(1'b1, 1'b1, 1'b1, 25'h1FFFFFF);
        step();
        redirect = 1'b0;
        step();
        checks++;
        if (if_pc !== 25'h1FFFFFF || inst !== 32'd1123) begin
            errors++;
            $display("FAIL wrap_top: got if_pc=%h inst=%0d, want 1ffffff/1123", if_pc, inst);
        end
        step();
        checks++;
        if (if_pc !== 25'h0 || inst !== 32'd100 || imem_addr !== 25'h1) begin
            errors++;
            $display("FAIL wrap_zero: got if_pc=%h inst=%0d addr=%h, want 0/100/1",
                     if_pc, inst, imem_addr);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 99) < 2);
            drive(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 9) < 1), 25'($urandom));
            step();
            checks++;
            if ({inst, if_pc, imem_addr} !== want) begin
                errors++;
                $display("FAIL random c=%0d: got %h %h %h, want %h",
                         c, inst, if_pc, imem_addr, want);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        mem_we = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < MemDepth; i++) begin
            mem_model[i] = 32'(100 + i);
            mem_we    = 1'b1;
            mem_waddr = MemAw'(i);
            mem_wdata = 32'(100 + i);
            @(posedge clk);
            #1;
        end
        mem_we = 1'b0;

        test_reset();
        test_sequential();
        test_decode_stall();
        test_redirect();
        test_redirect_in_hold();
        test_back_to_back();
        test_freeze();
        test_wrap();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
